// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and helpers for the RV32M multiply sequencer
//
// Holds the funct3[1:0] encodings of the M-extension multiply group, the
// sequencer FSM state type and the result-selection function used in the
// capture cycle.

package cpu_pkg;

  localparam logic [1:0] MUL_FUNCT3_MUL    = 2'b00;
  localparam logic [1:0] MUL_FUNCT3_MULH   = 2'b01;
  localparam logic [1:0] MUL_FUNCT3_MULHSU = 2'b10;
  localparam logic [1:0] MUL_FUNCT3_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mul_state_t;

  // Picks the 32-bit architectural result out of the 64-bit product.
  // For MULHSU the multiplier runs unsigned x unsigned; when rs1 is negative
  // the unsigned view of rs1 is 2^32 too large, so rs2 * 2^32 must be
  // removed from the product, i.e. rs2 subtracted from the upper half.
  function automatic logic [31:0] mul_select(
    input logic [1:0]  funct,
    input logic [63:0] product,
    input logic [31:0] rs1,
    input logic [31:0] rs2
  );
    logic [31:0] v_corr;
    logic [31:0] v_res;
    v_corr = rs1[31] ? rs2 : 32'd0;
    case (funct)
      MUL_FUNCT3_MUL:    v_res = product[31:0];
      MUL_FUNCT3_MULHSU: v_res = product[63:32] - v_corr;
      default:           v_res = product[63:32];
    endcase
    return v_res;
  endfunction

endpackage

// File: rtl/cpu_multiply_control.sv
// rtl/cpu_multiply_control.sv - RV32M multiply sequencer between issue and a fixed-latency multiplier
//
// Captures one MUL/MULH/MULHSU/MULHU under i_request/o_ready, drives the
// multiplier for one latch cycle, waits LATENCY cycles, selects and corrects
// the result and holds it under o_valid/i_accept.
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_request / o_ready       issue handshake
//   i_funct3, i_rs1, i_rs2    operation and operands (funct3[2] ignored)
//   i_rd                      destination register index
//   o_mul_latch               one-cycle multiplier latch strobe
//   o_mul_signed              multiplier signed mode (MULH only)
//   o_mul_op1, o_mul_op2      multiplier operands
//   i_mul_result              64-bit multiplier product
//   o_valid / i_accept        writeback handshake
//   o_rd, o_result            held destination index and result

module cpu_multiply_control
  import cpu_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  output logic        o_ready,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rd,
  output logic        o_mul_latch,
  output logic        o_mul_signed,
  output logic [31:0] o_mul_op1,
  output logic [31:0] o_mul_op2,
  input  logic [63:0] i_mul_result,
  output logic        o_valid,
  output logic [4:0]  o_rd,
  output logic [31:0] o_result,
  input  logic        i_accept
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  mul_state_t  r_state;
  mul_state_t  w_next;
  logic [3:0]  r_count;
  logic [1:0]  r_funct;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [4:0]  r_rd;
  logic        r_signed;
  logic        r_ready;
  logic        r_latch;
  logic        r_valid;
  logic [31:0] r_result;
  logic        w_accept_req;
  logic        w_capture;
  logic        w_unused_funct3;

  assign w_unused_funct3 = i_funct3[2];

  assign w_accept_req = (r_state == ST_IDLE) && i_request;
  assign w_capture    = (r_state == ST_WAIT) && (r_count == 4'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_request) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (r_count == 4'd0) w_next = ST_DONE;
      ST_DONE:  if (i_accept) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Handshake and strobe outputs are decoded from the next state so that
  // they are flops that line up exactly with the state they describe.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_count  <= 4'd0;
      r_funct  <= MUL_FUNCT3_MUL;
      r_op1    <= 32'd0;
      r_op2    <= 32'd0;
      r_rd     <= 5'd0;
      r_signed <= 1'b0;
      r_ready  <= 1'b1;
      r_latch  <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      r_latch <= (w_next == ST_ISSUE);
      r_valid <= (w_next == ST_DONE);

      if (w_accept_req) begin
        r_funct  <= i_funct3[1:0];
        r_op1    <= i_rs1;
        r_op2    <= i_rs2;
        r_rd     <= i_rd;
        r_signed <= (i_funct3[1:0] == MUL_FUNCT3_MULH);
      end

      if (r_state == ST_ISSUE) begin
        r_count <= CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end

      if (w_capture) begin
        r_result <= mul_select(r_funct, i_mul_result, r_op1, r_op2);
      end
    end
  end

  assign o_ready      = r_ready;
  assign o_mul_latch  = r_latch;
  assign o_mul_signed = r_signed;
  assign o_mul_op1    = r_op1;
  assign o_mul_op2    = r_op2;
  assign o_valid      = r_valid;
  assign o_rd         = r_rd;
  assign o_result     = r_result;

endmodule

// File: tb/tb_cpu_multiply_control.sv
// tb/tb_cpu_multiply_control.sv - self-checking bench for cpu_multiply_control

module tb_cpu_multiply_control;

  localparam int LAT = 2;
  localparam logic [63:0] JUNK = 64'hA5A5_5A5A_C3C3_3C3C;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_request;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [4:0]  i_rd;
  logic        o_mul_latch;
  logic        o_mul_signed;
  logic [31:0] o_mul_op1;
  logic [31:0] o_mul_op2;
  logic [63:0] i_mul_result;
  logic        o_valid;
  logic [4:0]  o_rd;
  logic [31:0] o_result;
  logic        i_accept;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cpu_multiply_control #(.LATENCY(LAT)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_request    (i_request),
    .o_ready      (o_ready),
    .i_funct3     (i_funct3),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .i_rd         (i_rd),
    .o_mul_latch  (o_mul_latch),
    .o_mul_signed (o_mul_signed),
    .o_mul_op1    (o_mul_op1),
    .o_mul_op2    (o_mul_op2),
    .i_mul_result (i_mul_result),
    .o_valid      (o_valid),
    .o_rd         (o_rd),
    .o_result     (o_result),
    .i_accept     (i_accept)
  );

  typedef struct {
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [63:0] product;
    logic [31:0] exp_result;
    logic        exp_signed;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  64'(o_ready), 64'd1);
    check({tag, "_valid"},  64'(o_valid), 64'd0);
    check({tag, "_latch"},  64'(o_mul_latch), 64'd0);
    check({tag, "_signed"}, 64'(o_mul_signed), 64'd0);
    check({tag, "_op1"},    64'(o_mul_op1), 64'd0);
    check({tag, "_op2"},    64'(o_mul_op2), 64'd0);
    check({tag, "_rd"},     64'(o_rd), 64'd0);
    check({tag, "_result"}, 64'(o_result), 64'd0);
  endtask

  // Entered and left at a negedge with the DUT expected to be idle.
  // hold: cycles to withhold i_accept in DONE while i_request stays high.
  task automatic run_op(input vec_t v, input int hold, input string tag);
    logic [31:0] held_result;
    logic [4:0]  held_rd;
    check({tag, "_ready_T"}, 64'(o_ready), 64'd1);
    i_request    = 1'b1;
    i_funct3     = v.funct3;
    i_rs1        = v.rs1;
    i_rs2        = v.rs2;
    i_rd         = v.rd;
    i_accept     = 1'b0;
    i_mul_result = JUNK;
    @(negedge clk);                       // cycle T+1 (ISSUE)
    i_request = 1'b0;
    i_rs1 = 32'h0BAD_F00D;
    i_rs2 = 32'h0DEF_ACED;
    i_rd  = 5'd9;
    check({tag, "_ready_T1"},  64'(o_ready), 64'd0);
    check({tag, "_latch_T1"},  64'(o_mul_latch), 64'd1);
    check({tag, "_signed_T1"}, 64'(o_mul_signed), 64'(v.exp_signed));
    check({tag, "_op1_T1"},    64'(o_mul_op1), 64'(v.rs1));
    check({tag, "_op2_T1"},    64'(o_mul_op2), 64'(v.rs2));
    for (int c = 1; c <= 1 + LAT; c++) begin
      if (c > 1) begin
        check({tag, "_latch_wait"}, 64'(o_mul_latch), 64'd0);
        check({tag, "_valid_wait"}, 64'(o_valid), 64'd0);
        check({tag, "_op1_wait"},   64'(o_mul_op1), 64'(v.rs1));
      end
      i_mul_result = (c == 1 + LAT) ? v.product : JUNK;
      @(negedge clk);
    end
    i_mul_result = JUNK;                  // cycle T+2+LAT (DONE)
    check({tag, "_valid_done"},  64'(o_valid), 64'd1);
    check({tag, "_result_done"}, 64'(o_result), 64'(v.exp_result));
    check({tag, "_rd_done"},     64'(o_rd), 64'(v.rd));
    check({tag, "_ready_done"},  64'(o_ready), 64'd0);
    held_result = o_result;
    held_rd     = o_rd;
    for (int h = 0; h < hold; h++) begin
      i_request = 1'b1;
      i_rs1     = 32'hFFFF_0000;
      @(negedge clk);
      check({tag, "_bp_valid"},  64'(o_valid), 64'd1);
      check({tag, "_bp_result"}, 64'(o_result), 64'(held_result));
      check({tag, "_bp_rd"},     64'(o_rd), 64'(held_rd));
      check({tag, "_bp_latch"},  64'(o_mul_latch), 64'd0);
      check({tag, "_bp_ready"},  64'(o_ready), 64'd0);
    end
    i_request = 1'b0;
    i_accept  = 1'b1;
    @(negedge clk);
    i_accept = 1'b0;
    check({tag, "_valid_after"}, 64'(o_valid), 64'd0);
    check({tag, "_ready_after"}, 64'(o_ready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{3'b000, 32'd7,          32'd6,          5'd5,  64'h0000_0000_0000_002A, 32'h0000_002A, 1'b0};
    vecs[1] = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[2] = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{3'b010, 32'h0000_0002,  32'hFFFF_FFFF,  5'd2,  64'h0000_0001_FFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[4] = '{3'b001, 32'h8000_0000,  32'h8000_0000,  5'd3,  64'h4000_0000_0000_0000, 32'h4000_0000, 1'b1};
    vecs[5] = '{3'b100, 32'h1234_5678,  32'h0000_0010,  5'd4,  64'h0000_0001_2345_6780, 32'h2345_6780, 1'b0};
    vecs[6] = '{3'b010, 32'h8000_0000,  32'h0000_0003,  5'd6,  64'h0000_0001_8000_0000, 32'hFFFF_FFFE, 1'b0};

    i_reset = 1'b1;
    i_request = 1'b0;
    i_funct3 = 3'b000;
    i_rs1 = 32'd0;
    i_rs2 = 32'd0;
    i_rd = 5'd0;
    i_mul_result = JUNK;
    i_accept = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    i_reset = 1'b0;

    // Accept without a pending result does nothing.
    i_accept = 1'b1;
    @(negedge clk);
    i_accept = 1'b0;
    check("idle_accept_valid", 64'(o_valid), 64'd0);
    check("idle_accept_ready", 64'(o_ready), 64'd1);

    foreach (vecs[i]) run_op(vecs[i], 0, $sformatf("vec%0d", i));

    // Backpressure, then the follow-up op is taken immediately.
    run_op(vecs[0], 5, "bp");
    run_op(vecs[3], 0, "bp_next");

    // Reset during WAIT abandons the operation.
    i_request = 1'b1;
    i_funct3  = 3'b001;
    i_rs1     = 32'h1111_1111;
    i_rs2     = 32'h2222_2222;
    i_rd      = 5'd17;
    @(negedge clk);                       // ISSUE
    i_request = 1'b0;
    @(negedge clk);                       // WAIT
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check_reset_outputs("rst_wait");
    for (int c = 0; c < LAT + 4; c++) begin
      i_mul_result = 64'h3333_3333_4444_4444;
      @(negedge clk);
      check("rst_wait_no_valid", 64'(o_valid), 64'd0);
    end
    i_mul_result = JUNK;

    // Reset and accept together in DONE: reset clears the held result.
    i_request = 1'b1;
    i_funct3  = 3'b000;
    i_rs1     = 32'd3;
    i_rs2     = 32'd5;
    i_rd      = 5'd8;
    @(negedge clk);
    i_request = 1'b0;
    for (int c = 1; c <= 1 + LAT; c++) begin
      i_mul_result = (c == 1 + LAT) ? 64'd15 : JUNK;
      @(negedge clk);
    end
    check("rst_acc_valid_before", 64'(o_valid), 64'd1);
    check("rst_acc_result_before", 64'(o_result), 64'd15);
    i_reset  = 1'b1;
    i_accept = 1'b1;
    @(negedge clk);
    i_reset  = 1'b0;
    i_accept = 1'b0;
    check_reset_outputs("rst_acc");

    run_op(vecs[4], 0, "recover");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_multiply_control.md
# cpu_multiply_control

Sequencer for the RV32M multiply instructions (MUL, MULH, MULHSU, MULHU) in the execute stage. It sits between the decode/issue logic and the 64-bit multiplier datapath. It captures an operation under a valid/ready handshake and drives the multiplier's latch, signed and operand inputs. It waits out the multiplier's fixed latency, selects the required 32-bit half and applies the MULHSU sign correction. The finished result is held for writeback under a second valid/accept handshake.

## Interface
Parameters:
- LATENCY, 2: cycles from the multiplier latch cycle until its 64-bit result is valid; range 1..15.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  1  issue strobe: operation valid.
- o_ready  out  1  block idle and able to accept a request.
- i_funct3  in  3  [1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; bit 2 must be 0 and is ignored.
- i_rs1, i_rs2  in  32  source operands.
- i_rd  in  5  destination register index.
- o_mul_latch  out  1  multiplier latch strobe.
- o_mul_signed  out  1  multiplier signed mode.
- o_mul_op1, o_mul_op2  out  32  multiplier operands.
- i_mul_result  in  64  multiplier product.
- o_valid  out  1  result available for writeback.
- o_rd  out  5  destination index of the held result.
- o_result  out  32  selected result.
- i_accept  in  1  writeback consumed the result.

## Operation
- FSM states and transitions:
  - IDLE: o_ready=1. When i_request=1, register funct3[1:0], rs1, rs2 and rd, then go to ISSUE.
  - ISSUE: one cycle with o_mul_latch=1. Load the counter with LATENCY-1, then go to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle where the counter is 0, capture i_mul_result into the result stage and go to DONE.
  - DONE: o_valid=1. When i_accept=1, go to IDLE.
- o_mul_op1/op2 are driven from the registered operands and held stable from ISSUE through the capture cycle.
- o_mul_signed is 1 only for MULH; it is 0 for MUL, MULHU and MULHSU.
- Result selection (P = i_mul_result):
  - MUL: P[31:0].
  - MULH and MULHU: P[63:32].
  - MULHSU: P[63:32] − (rs1[31] ? rs2 : 0), computed modulo 2^32. This corrects an unsigned product to signed×unsigned.
- The correction is computed in the capture cycle and registered into o_result.
- o_rd, o_result and o_valid stay stable throughout DONE until accepted.
- i_request is ignored outside IDLE.
- Reset mid-operation: the operation is abandoned with no writeback and no o_valid pulse. The multiplier's internal state is a don't-care.

## Timing
- All outputs are registered.
- Reset values: o_ready=1, o_valid=0, o_mul_latch=0, o_mul_signed=0, o_mul_op1=0, o_mul_op2=0, o_rd=0, o_result=0, FSM=IDLE.
- Request accepted at cycle T:
  - o_ready=0 from T+1.
  - o_mul_latch=1 at T+1 only.
  - Product sampled at T+1+LATENCY.
  - o_valid=1 from T+2+LATENCY.
- Zero-wait accept (i_accept=1 during the first o_valid cycle): IDLE at the next cycle, so a new request can be accepted then. Peak issue rate is one operation per LATENCY+3 cycles.
- i_accept while o_valid=0 has no effect.
- Simultaneous i_reset and i_accept: reset wins.

## Structure
- Shared package cpu_pkg holds:
  - funct3 encodings MUL_FUNCT3_MUL/MULH/MULHSU/MULHU.
  - The FSM state enumeration.
- No sub-module: this block is a single FSM plus counter plus result mux. The multiplier datapath is instantiated by the parent execute stage and connected through the o_mul_* / i_mul_result ports.

## Test plan
- MUL, rs1=7, rs2=6 -> o_result=0x0000002A, o_mul_latch pulses once, o_valid at T+2+LATENCY.
- MULHU, rs1=rs2=0xFFFFFFFF, product 0xFFFFFFFE_00000001 -> o_result=0xFFFFFFFE, o_mul_signed=0.
- MULHSU, rs1=rs2=0xFFFFFFFF, multiplier returns 0xFFFFFFFE_00000001 -> o_result=0xFFFFFFFF. Same op with rs1=0x00000002, rs2=0xFFFFFFFF -> o_result=0x00000001.
- MULH, rs1=rs2=0x80000000, multiplier returns 0x40000000_00000000 -> o_result=0x40000000, o_mul_signed=1 during ISSUE.
- Backpressure: hold i_accept=0 for 5 cycles in DONE, with i_request=1 throughout -> o_valid/o_result/o_rd stable and no second latch. Accept -> IDLE next cycle, then the second op is accepted.
- Reset asserted in WAIT -> the next cycle shows o_ready=1 and o_valid=0, all outputs at reset values, and no o_valid pulse for the aborted op.
